// File: rtl/tlb_maint_ctrl_pkg.sv
// Shared definitions for the TLB maintenance controller: op codes, INVTLB
// sub-op codes, page-size encodings and the controller state encoding.
package tlb_maint_ctrl_pkg;

    localparam int             TLBNUM_DEF    = 16;
    localparam int             IDX_W_DEF     = 4;
    localparam logic [3:0]     LFSR_SEED_DEF = 4'b1010;
    localparam logic [3:0]     LFSR_TAPS_DEF = 4'b1100;

    localparam logic [5:0]     PS_4K = 6'd12;
    localparam logic [5:0]     PS_4M = 6'd21;

    typedef enum logic [2:0] {
        OP_SRCH = 3'd0,
        OP_RD   = 3'd1,
        OP_WR   = 3'd2,
        OP_FILL = 3'd3,
        OP_INV  = 3'd4
    } tlb_op_e;

    typedef enum logic [4:0] {
        INV_ALL0      = 5'd0,
        INV_ALL1      = 5'd1,
        INV_G         = 5'd2,
        INV_NG        = 5'd3,
        INV_NG_ASID   = 5'd4,
        INV_NG_ASID_V = 5'd5,
        INV_GA_V      = 5'd6
    } inv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_SWEEP = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/tlb_maint_ctrl_lfsr.sv
// Free-running Galois LFSR that supplies the TLBFILL replacement index.
// With a nonzero seed and primitive taps it never reaches the all-zero state.
module tlb_lfsr #(
    parameter int               IDX_W = 4,
    parameter logic [IDX_W-1:0] SEED  = 4'b1010,
    parameter logic [IDX_W-1:0] TAPS  = 4'b1100
) (
    input  logic             clk,
    input  logic             resetn,
    output logic [IDX_W-1:0] rnd
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rnd <= SEED;
        end else begin
            rnd <= (rnd >> 1) ^ ({IDX_W{rnd[0]}} & TAPS);
        end
    end

endmodule

// File: rtl/tlb_maint_ctrl.sv
// TLB maintenance sequencer: runs one committed TLBSRCH/TLBRD/TLBWR/TLBFILL
// op per handshake, or a full-array INVTLB sweep, then pulses done/refetch.
module tlb_maint_ctrl
    import tlb_maint_ctrl_pkg::*;
#(
    parameter int               TLBNUM    = TLBNUM_DEF,
    parameter int               IDX_W     = $clog2(TLBNUM),
    parameter logic [IDX_W-1:0] LFSR_SEED = LFSR_SEED_DEF,
    parameter logic [IDX_W-1:0] LFSR_TAPS = LFSR_TAPS_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op_code,
    input  logic             op_srch_hit,
    input  logic [IDX_W-1:0] op_srch_idx,
    input  logic [4:0]       inv_op,
    input  logic [9:0]       inv_asid,
    input  logic [18:0]      inv_vppn,
    input  logic [IDX_W-1:0] csr_tlbidx_index,
    output logic [IDX_W-1:0] r_index,
    input  logic             r_e,
    input  logic             r_g,
    input  logic [9:0]       r_asid,
    input  logic [18:0]      r_vppn,
    input  logic [5:0]       r_ps,
    output logic             tlbrd_we,
    output logic             tlbsrch_we,
    output logic             tlbsrch_hit,
    output logic [IDX_W-1:0] tlbsrch_hit_index,
    output logic             tlb_we,
    output logic [IDX_W-1:0] w_index,
    output logic             inv_we,
    output logic [IDX_W-1:0] inv_index,
    output logic             op_done,
    output logic             refetch
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLBNUM - 1);

    state_e           state;
    state_e           state_next;
    logic             accept;
    logic [2:0]       op_q;
    logic [4:0]       inv_op_q;
    logic [9:0]       inv_asid_q;
    logic [18:0]      inv_vppn_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] fill_idx_q;
    logic             srch_hit_q;
    logic [IDX_W-1:0] srch_idx_q;
    logic [IDX_W-1:0] sweep_idx;
    logic [IDX_W-1:0] lfsr_rnd;
    logic             asid_eq;
    logic             vm;
    logic             match;

    tlb_lfsr #(
        .IDX_W (IDX_W),
        .SEED  (LFSR_SEED),
        .TAPS  (LFSR_TAPS)
    ) u_lfsr (
        .clk    (clk),
        .resetn (resetn),
        .rnd    (lfsr_rnd)
    );

    assign accept            = op_valid && (state == ST_IDLE);
    assign tlbsrch_hit       = srch_hit_q;
    assign tlbsrch_hit_index = srch_idx_q;

    // All op operands are captured at accept so WB may move on; the fill
    // index is the LFSR value of the accept cycle, not of the write cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            op_q       <= '0;
            inv_op_q   <= '0;
            inv_asid_q <= '0;
            inv_vppn_q <= '0;
            idx_q      <= '0;
            fill_idx_q <= '0;
            srch_hit_q <= 1'b0;
            srch_idx_q <= '0;
            sweep_idx  <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_q       <= op_code;
                inv_op_q   <= inv_op;
                inv_asid_q <= inv_asid;
                inv_vppn_q <= inv_vppn;
                idx_q      <= csr_tlbidx_index;
                fill_idx_q <= lfsr_rnd;
                sweep_idx  <= '0;
                if (op_code == OP_SRCH) begin
                    srch_hit_q <= op_srch_hit;
                    srch_idx_q <= op_srch_idx;
                end
            end
            if (state == ST_SWEEP) begin
                sweep_idx <= sweep_idx + IDX_W'(1);
            end
        end
    end

    // A 4M page compares only the upper VPPN bits; 4K compares all of them.
    always_comb begin
        asid_eq = (r_asid == inv_asid_q);
        if (r_ps == PS_4M) begin
            vm = (r_vppn[18:9] == inv_vppn_q[18:9]);
        end else begin
            vm = (r_vppn == inv_vppn_q);
        end
        case (inv_op_q)
            INV_ALL0, INV_ALL1: match = r_e;
            INV_G:              match = r_e & r_g;
            INV_NG:             match = r_e & ~r_g;
            INV_NG_ASID:        match = r_e & ~r_g & asid_eq;
            INV_NG_ASID_V:      match = r_e & ~r_g & asid_eq & vm;
            INV_GA_V:           match = r_e & (r_g | asid_eq) & vm;
            default:            match = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        op_ready   = 1'b0;
        r_index    = csr_tlbidx_index;
        tlbrd_we   = 1'b0;
        tlbsrch_we = 1'b0;
        tlb_we     = 1'b0;
        w_index    = '0;
        inv_we     = 1'b0;
        inv_index  = '0;
        op_done    = 1'b0;
        refetch    = 1'b0;
        case (state)
            ST_IDLE: begin
                op_ready = 1'b1;
                if (accept) begin
                    if (op_code == OP_INV) begin
                        state_next = ST_SWEEP;
                    end else if (op_code <= OP_FILL) begin
                        state_next = ST_EXEC;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_EXEC: begin
                state_next = ST_DONE;
                case (op_q)
                    OP_SRCH: tlbsrch_we = 1'b1;
                    OP_RD: begin
                        r_index  = idx_q;
                        tlbrd_we = 1'b1;
                    end
                    OP_WR: begin
                        tlb_we  = 1'b1;
                        w_index = idx_q;
                    end
                    OP_FILL: begin
                        tlb_we  = 1'b1;
                        w_index = fill_idx_q;
                    end
                    default: ;
                endcase
            end
            ST_SWEEP: begin
                r_index   = sweep_idx;
                inv_we    = match;
                inv_index = sweep_idx;
                if (sweep_idx == LAST_IDX) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                op_done    = 1'b1;
                refetch    = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_tlb_maint_ctrl.sv
// Directed self-checking bench for tlb_maint_ctrl with a small TLB entry table
// answering the read port and a reference LFSR for the fill index.
module tb_tlb_maint_ctrl;

    logic        clk;
    logic        resetn;
    logic        op_valid;
    logic        op_ready;
    logic [2:0]  op_code;
    logic        op_srch_hit;
    logic [3:0]  op_srch_idx;
    logic [4:0]  inv_op;
    logic [9:0]  inv_asid;
    logic [18:0] inv_vppn;
    logic [3:0]  csr_tlbidx_index;
    logic [3:0]  r_index;
    logic        r_e;
    logic        r_g;
    logic [9:0]  r_asid;
    logic [18:0] r_vppn;
    logic [5:0]  r_ps;
    logic        tlbrd_we;
    logic        tlbsrch_we;
    logic        tlbsrch_hit;
    logic [3:0]  tlbsrch_hit_index;
    logic        tlb_we;
    logic [3:0]  w_index;
    logic        inv_we;
    logic [3:0]  inv_index;
    logic        op_done;
    logic        refetch;

    logic        ent_e    [16];
    logic        ent_g    [16];
    logic [9:0]  ent_asid [16];
    logic [18:0] ent_vppn [16];
    logic [5:0]  ent_ps   [16];

    logic [3:0]  lfsr_model;
    int          n_checks;
    int          n_fail;

    tlb_maint_ctrl dut (
        .clk               (clk),
        .resetn            (resetn),
        .op_valid          (op_valid),
        .op_ready          (op_ready),
        .op_code           (op_code),
        .op_srch_hit       (op_srch_hit),
        .op_srch_idx       (op_srch_idx),
        .inv_op            (inv_op),
        .inv_asid          (inv_asid),
        .inv_vppn          (inv_vppn),
        .csr_tlbidx_index  (csr_tlbidx_index),
        .r_index           (r_index),
        .r_e               (r_e),
        .r_g               (r_g),
        .r_asid            (r_asid),
        .r_vppn            (r_vppn),
        .r_ps              (r_ps),
        .tlbrd_we          (tlbrd_we),
        .tlbsrch_we        (tlbsrch_we),
        .tlbsrch_hit       (tlbsrch_hit),
        .tlbsrch_hit_index (tlbsrch_hit_index),
        .tlb_we            (tlb_we),
        .w_index           (w_index),
        .inv_we            (inv_we),
        .inv_index         (inv_index),
        .op_done           (op_done),
        .refetch           (refetch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        r_e    = ent_e[r_index];
        r_g    = ent_g[r_index];
        r_asid = ent_asid[r_index];
        r_vppn = ent_vppn[r_index];
        r_ps   = ent_ps[r_index];
    end

    // Reference x^4+x^3+1 Galois sequence: a,5,e,7,f,b,9,8,4,2,1,c,6,3,d
    always @(posedge clk or negedge resetn) begin
        if (!resetn) lfsr_model <= 4'b1010;
        else         lfsr_model <= (lfsr_model >> 1) ^ (lfsr_model[0] ? 4'b1100 : 4'b0000);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [2:0] code, input logic hold);
        op_code  = code;
        op_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) op_valid = 1'b0;
    endtask

    task automatic run_sweep(output int done_k, output logic [15:0] mask,
                             output logic [3:0] first_r, output logic rdy_mid,
                             output logic refetch_at_done);
        done_k          = 0;
        mask            = '0;
        first_r         = 'x;
        rdy_mid         = 'x;
        refetch_at_done = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) first_r = r_index;
            if (k == 8) rdy_mid = op_ready;
            if (inv_we === 1'b1) mask[inv_index] = 1'b1;
            if (op_done === 1'b1) begin
                done_k          = k;
                refetch_at_done = refetch;
                break;
            end
        end
    endtask

    initial begin
        int          done_k;
        logic [15:0] mask;
        logic [3:0]  first_r;
        logic        rdy_mid;
        logic        rf;
        int          waited;

        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 16; i++) begin
            ent_e[i]    = 1'b0;
            ent_g[i]    = 1'b0;
            ent_asid[i] = '0;
            ent_vppn[i] = '0;
            ent_ps[i]   = 6'd12;
        end
        ent_e[2]  = 1'b1; ent_g[2]  = 1'b0; ent_asid[2]  = 10'd3; ent_vppn[2]  = 19'h12345; ent_ps[2]  = 6'd12;
        ent_e[4]  = 1'b1; ent_g[4]  = 1'b1; ent_asid[4]  = 10'd5; ent_vppn[4]  = 19'h123EE; ent_ps[4]  = 6'd21;
        ent_e[7]  = 1'b1; ent_g[7]  = 1'b1; ent_asid[7]  = 10'd3; ent_vppn[7]  = 19'h12345; ent_ps[7]  = 6'd12;
        ent_e[9]  = 1'b1; ent_g[9]  = 1'b0; ent_asid[9]  = 10'd4; ent_vppn[9]  = 19'h12345; ent_ps[9]  = 6'd12;
        ent_e[11] = 1'b1; ent_g[11] = 1'b0; ent_asid[11] = 10'd3; ent_vppn[11] = 19'h12344; ent_ps[11] = 6'd12;

        resetn           = 1'b0;
        op_valid         = 1'b0;
        op_code          = '0;
        op_srch_hit      = 1'b0;
        op_srch_idx      = '0;
        inv_op           = '0;
        inv_asid         = '0;
        inv_vppn         = '0;
        csr_tlbidx_index = '0;

        repeat (3) @(negedge clk);
        check("reset op_ready", op_ready, 1);
        check("reset tlb_we", tlb_we, 0);
        check("reset inv_we", inv_we, 0);
        check("reset op_done", op_done, 0);
        check("reset refetch", refetch, 0);
        check("reset tlbsrch_hit", tlbsrch_hit, 0);

        // FILL accepted on the first edge after reset sees the seed value
        #1 resetn = 1'b1;
        start_op(3'd3, 1'b0);
        @(negedge clk);
        check("fill0 tlb_we", tlb_we, 1);
        check("fill0 w_index seed", w_index, 4'ha);
        @(negedge clk);
        check("fill0 op_done", op_done, 1);
        @(negedge clk);

        csr_tlbidx_index = 4'd5;
        start_op(3'd2, 1'b0);
        @(negedge clk);
        check("wr tlb_we", tlb_we, 1);
        check("wr w_index", w_index, 5);
        check("wr op_done early", op_done, 0);
        check("wr op_ready busy", op_ready, 0);
        @(negedge clk);
        check("wr op_done", op_done, 1);
        check("wr refetch", refetch, 1);
        check("wr tlb_we dropped", tlb_we, 0);
        @(negedge clk);
        check("wr op_ready back", op_ready, 1);
        check("wr op_done cleared", op_done, 0);

        csr_tlbidx_index = 4'd3;
        start_op(3'd1, 1'b0);
        csr_tlbidx_index = 4'd11;
        @(negedge clk);
        check("rd tlbrd_we", tlbrd_we, 1);
        check("rd r_index latched", r_index, 3);
        @(negedge clk);
        check("rd op_done", op_done, 1);
        check("rd r_index csr in done", r_index, 11);
        @(negedge clk);

        op_srch_hit = 1'b1;
        op_srch_idx = 4'd6;
        start_op(3'd0, 1'b0);
        op_srch_hit = 1'b0;
        op_srch_idx = 4'd1;
        @(negedge clk);
        check("srch tlbsrch_we", tlbsrch_we, 1);
        check("srch hit", tlbsrch_hit, 1);
        check("srch hit_index", tlbsrch_hit_index, 6);
        @(negedge clk);
        check("srch op_done", op_done, 1);
        @(negedge clk);

        start_op(3'd5, 1'b0);
        @(negedge clk);
        check("rsvd op_done at +1", op_done, 1);
        check("rsvd tlb_we", tlb_we, 0);
        check("rsvd inv_we", inv_we, 0);
        check("rsvd srch hit held", tlbsrch_hit, 1);
        check("rsvd srch idx held", tlbsrch_hit_index, 6);
        @(negedge clk);
        check("rsvd op_ready back", op_ready, 1);

        // Present a FILL exactly when the LFSR holds 9
        waited = 0;
        while (lfsr_model != 4'd9 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("lfsr reaches 9", (lfsr_model == 4'd9), 1);
        start_op(3'd3, 1'b0);
        @(negedge clk);
        check("fill9 tlb_we", tlb_we, 1);
        check("fill9 w_index", w_index, 9);
        @(negedge clk);
        check("fill9 op_done", op_done, 1);
        @(negedge clk);

        inv_op   = 5'd5;
        inv_asid = 10'd3;
        inv_vppn = 19'h12345;
        start_op(3'd4, 1'b0);
        run_sweep(done_k, mask, first_r, rdy_mid, rf);
        check("inv5 done cycle", done_k, 17);
        check("inv5 cleared set", mask, 16'h0004);
        check("inv5 first r_index", first_r, 0);
        check("inv5 refetch", rf, 1);
        @(negedge clk);

        inv_op = 5'd6;
        start_op(3'd4, 1'b1);
        run_sweep(done_k, mask, first_r, rdy_mid, rf);
        op_valid = 1'b0;
        check("inv6 op_ready mid sweep", rdy_mid, 0);
        check("inv6 cleared set", mask, 16'h0094);
        check("inv6 done cycle", done_k, 17);
        @(negedge clk);

        inv_op           = 5'd4;
        inv_asid         = 10'd4;
        csr_tlbidx_index = 4'd13;
        start_op(3'd4, 1'b0);
        for (int k = 1; k <= 9; k++) @(negedge clk);
        check("inv4 r_index before reset", r_index, 8);
        #1 resetn = 1'b0;
        #1;
        check("async rst inv_we", inv_we, 0);
        check("async rst op_ready", op_ready, 1);
        check("async rst r_index", r_index, 13);
        @(negedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        start_op(3'd4, 1'b0);
        run_sweep(done_k, mask, first_r, rdy_mid, rf);
        check("inv4 restart first r_index", first_r, 0);
        check("inv4 cleared set", mask, 16'h0200);
        check("inv4 done cycle", done_k, 17);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
